// File: rtl/axi_pkg.sv
// Shared AXI read-slave definitions: default bus widths, burst encodings, response codes
// and the AR request record used by axi_rd_mem_slave and axi_rd_burst_addr.
package axi_pkg;

  localparam int AXI_ID_WIDTH   = 4;
  localparam int AXI_ADDR_WIDTH = 32;
  localparam int AXI_DATA_WIDTH = 32;
  localparam int AXI_LEN_WIDTH  = 8;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10
  } burst_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef struct packed {
    logic [AXI_ID_WIDTH-1:0]   id;
    logic [AXI_ADDR_WIDTH-1:0] addr;
    logic [AXI_LEN_WIDTH-1:0]  len;
    logic [2:0]                size;
    logic [1:0]                burst;
  } ar_req_t;

endpackage

// File: rtl/axi_rd_burst_addr.sv
// Combinational beat address step and error classification for one AXI read beat:
// next address (FIXED/INCR/WRAP), memory word index, request-wide and per-beat SLVERR flags.
module axi_rd_burst_addr
  import axi_pkg::*;
#(
  parameter int ADDR_WIDTH = AXI_ADDR_WIDTH,
  parameter int DATA_WIDTH = AXI_DATA_WIDTH,
  parameter int LEN_WIDTH  = AXI_LEN_WIDTH,
  parameter int MEM_DEPTH  = 256
) (
  input  logic [ADDR_WIDTH-1:0]        addr_i,
  input  logic [LEN_WIDTH-1:0]         len_i,
  input  logic [2:0]                   size_i,
  input  logic [1:0]                   burst_i,
  output logic [ADDR_WIDTH-1:0]        next_addr_o,
  output logic [$clog2(MEM_DEPTH)-1:0] word_idx_o,
  output logic                         req_err_o,
  output logic                         beat_err_o
);

  localparam int OFFS = $clog2(DATA_WIDTH / 8);
  localparam int MW   = $clog2(MEM_DEPTH);

  logic [ADDR_WIDTH-1:0] step;
  logic [ADDR_WIDTH-1:0] incr;
  logic [ADDR_WIDTH-1:0] mask;
  logic [ADDR_WIDTH-1:0] idx_full;
  logic                  wrap_ok;

  always_comb begin
    step     = ADDR_WIDTH'(1) << size_i;
    incr     = addr_i + step;
    mask     = ((ADDR_WIDTH'(len_i) + ADDR_WIDTH'(1)) << size_i) - ADDR_WIDTH'(1);
    wrap_ok  = (len_i == LEN_WIDTH'(1)) || (len_i == LEN_WIDTH'(3)) ||
               (len_i == LEN_WIDTH'(7)) || (len_i == LEN_WIDTH'(15));
    idx_full = addr_i >> OFFS;

    req_err_o  = (int'(size_i) > OFFS) || (burst_i == 2'b11) ||
                 ((burst_i == BURST_WRAP) && !wrap_ok);
    beat_err_o = idx_full >= ADDR_WIDTH'(MEM_DEPTH);
    word_idx_o = idx_full[MW-1:0];

    // Reserved bursts and illegal-length WRAPs still walk the address like INCR.
    case (burst_i)
      BURST_FIXED: next_addr_o = addr_i;
      BURST_WRAP:  next_addr_o = wrap_ok ? ((addr_i & ~mask) | (incr & mask)) : incr;
      default:     next_addr_o = incr;
    endcase
  end

endmodule

// File: rtl/axi_rd_mem_slave.sv
// AXI4 read-side memory slave with sideband-loaded memory. Define AXI_RD_MEM_AR_FIFO_EN to
// accept up to AR_FIFO_DEPTH outstanding AR requests; otherwise one burst at a time.
module axi_rd_mem_slave
  import axi_pkg::*;
#(
  parameter int ID_WIDTH   = AXI_ID_WIDTH,
  parameter int ADDR_WIDTH = AXI_ADDR_WIDTH,
  parameter int DATA_WIDTH = AXI_DATA_WIDTH,
  parameter int LEN_WIDTH  = AXI_LEN_WIDTH,
  parameter int MEM_DEPTH  = 256
`ifdef AXI_RD_MEM_AR_FIFO_EN
  ,
  parameter int AR_FIFO_DEPTH = 4
`endif
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [ID_WIDTH-1:0]          arid_i,
  input  logic [ADDR_WIDTH-1:0]        araddr_i,
  input  logic [LEN_WIDTH-1:0]         arlen_i,
  input  logic [2:0]                   arsize_i,
  input  logic [1:0]                   arburst_i,
  input  logic                         arvalid_i,
  output logic                         arready_o,
  output logic [ID_WIDTH-1:0]          rid_o,
  output logic [DATA_WIDTH-1:0]        rdata_o,
  output logic [1:0]                   rresp_o,
  output logic                         rlast_o,
  output logic                         rvalid_o,
  input  logic                         rready_i,
  input  logic                         mem_we_i,
  input  logic [$clog2(MEM_DEPTH)-1:0] mem_waddr_i,
  input  logic [DATA_WIDTH-1:0]        mem_wdata_i
);

`ifdef AXI_RD_MEM_AR_FIFO_EN
  localparam int QDEPTH = AR_FIFO_DEPTH;
`else
  localparam int QDEPTH = 1;
`endif
  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW = $clog2(QDEPTH + 1);
  localparam int MW = $clog2(MEM_DEPTH);

  typedef enum logic {ST_IDLE, ST_BURST} state_e;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (int'(p) == QDEPTH - 1) return '0;
    return p + 1'b1;
  endfunction

  logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

  // The queue holds every accepted request; its head is the burst being returned.
  logic [ID_WIDTH-1:0]   q_id_q    [QDEPTH];
  logic [ADDR_WIDTH-1:0] q_addr_q  [QDEPTH];
  logic [LEN_WIDTH-1:0]  q_len_q   [QDEPTH];
  logic [2:0]            q_size_q  [QDEPTH];
  logic [1:0]            q_burst_q [QDEPTH];
  logic [PW-1:0]         rd_ptr_q, wr_ptr_q, nx_ptr;
  logic [CW-1:0]         count_q, count_d;

  state_e                state_q;
  logic                  arready_q, rvalid_q, rlast_q;
  logic [ID_WIDTH-1:0]   rid_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [1:0]            rresp_q;

  logic [ID_WIDTH-1:0]   cur_id_q;
  logic [ADDR_WIDTH-1:0] cur_addr_q;
  logic [LEN_WIDTH-1:0]  cur_len_q, cnt_q;
  logic [2:0]            cur_size_q;
  logic [1:0]            cur_burst_q;

  logic                  push, pop, beat_hs, last_hs, start_new, load;
  logic [ID_WIDTH-1:0]   src_id;
  logic [ADDR_WIDTH-1:0] src_addr, next_addr;
  logic [LEN_WIDTH-1:0]  src_len, src_cnt;
  logic [2:0]            src_size;
  logic [1:0]            src_burst;
  logic [MW-1:0]         word_idx;
  logic                  req_err, beat_err;

  assign beat_hs   = rvalid_q && rready_i;
  assign last_hs   = beat_hs && rlast_q;
  assign push      = arvalid_i && arready_q;
  assign pop       = last_hs;
  assign nx_ptr    = ptr_inc(rd_ptr_q);
  assign count_d   = count_q + CW'(push) - CW'(pop);
  assign start_new = ((state_q == ST_IDLE) && push) ||
                     (last_hs && ((int'(count_q) > 1) || push));
  assign load      = start_new || ((state_q == ST_BURST) && beat_hs && !rlast_q);

  always_comb begin
    src_id    = cur_id_q;
    src_addr  = cur_addr_q;
    src_len   = cur_len_q;
    src_size  = cur_size_q;
    src_burst = cur_burst_q;
    src_cnt   = cnt_q;
    if (start_new) begin
      src_cnt = '0;
      if ((state_q == ST_BURST) && (int'(count_q) > 1)) begin
        src_id    = q_id_q[nx_ptr];
        src_addr  = q_addr_q[nx_ptr];
        src_len   = q_len_q[nx_ptr];
        src_size  = q_size_q[nx_ptr];
        src_burst = q_burst_q[nx_ptr];
      end else begin
        src_id    = arid_i;
        src_addr  = araddr_i;
        src_len   = arlen_i;
        src_size  = arsize_i;
        src_burst = arburst_i;
      end
    end
  end

  axi_rd_burst_addr #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .LEN_WIDTH  (LEN_WIDTH),
    .MEM_DEPTH  (MEM_DEPTH)
  ) u_burst_addr (
    .addr_i      (src_addr),
    .len_i       (src_len),
    .size_i      (src_size),
    .burst_i     (src_burst),
    .next_addr_o (next_addr),
    .word_idx_o  (word_idx),
    .req_err_o   (req_err),
    .beat_err_o  (beat_err)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rid_q     <= '0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
      count_q   <= '0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
    end else begin
      arready_q <= (int'(count_d) != QDEPTH);
      count_q   <= count_d;
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= nx_ptr;
      if (load) begin
        state_q     <= ST_BURST;
        rvalid_q    <= 1'b1;
        rid_q       <= src_id;
        rlast_q     <= (src_cnt == src_len);
        rresp_q     <= (req_err || beat_err) ? RESP_SLVERR : RESP_OKAY;
        rdata_q     <= (req_err || beat_err) ? '0 : mem_q[word_idx];
        cur_id_q    <= src_id;
        cur_addr_q  <= next_addr;
        cur_len_q   <= src_len;
        cur_size_q  <= src_size;
        cur_burst_q <= src_burst;
        cnt_q       <= src_cnt + 1'b1;
      end else if (last_hs) begin
        state_q  <= ST_IDLE;
        rvalid_q <= 1'b0;
        rlast_q  <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      q_id_q[wr_ptr_q]    <= arid_i;
      q_addr_q[wr_ptr_q]  <= araddr_i;
      q_len_q[wr_ptr_q]   <= arlen_i;
      q_size_q[wr_ptr_q]  <= arsize_i;
      q_burst_q[wr_ptr_q] <= arburst_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (mem_we_i && (int'(mem_waddr_i) < MEM_DEPTH)) mem_q[mem_waddr_i] <= mem_wdata_i;
  end

  assign arready_o = arready_q;
  assign rvalid_o  = rvalid_q;
  assign rlast_o   = rlast_q;
  assign rid_o     = rid_q;
  assign rdata_o   = rdata_q;
  assign rresp_o   = rresp_q;

endmodule

// File: tb/tb_axi_rd_mem_slave.sv
// Directed self-checking bench for axi_rd_mem_slave (default widths, MEM_DEPTH 256).
module tb_axi_rd_mem_slave;

  localparam logic [31:0] D0 = 32'hA0A0_A0A0;
  localparam logic [31:0] D1 = 32'hA1A1_A1A1;
  localparam logic [31:0] D2 = 32'hA2A2_A2A2;
  localparam logic [31:0] D3 = 32'hA3A3_A3A3;
  localparam logic [31:0] DL = 32'hFF00_FF00;
  localparam logic [31:0] N1 = 32'h5555_1111;
  localparam logic [31:0] N2 = 32'h7777_2222;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid, arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast, rvalid, rready;
  logic        mem_we;
  logic [7:0]  mem_waddr;
  logic [31:0] mem_wdata;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  axi_rd_mem_slave #(.MEM_DEPTH(256)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .arid_i      (arid),
    .araddr_i    (araddr),
    .arlen_i     (arlen),
    .arsize_i    (arsize),
    .arburst_i   (arburst),
    .arvalid_i   (arvalid),
    .arready_o   (arready),
    .rid_o       (rid),
    .rdata_o     (rdata),
    .rresp_o     (rresp),
    .rlast_o     (rlast),
    .rvalid_o    (rvalid),
    .rready_i    (rready),
    .mem_we_i    (mem_we),
    .mem_waddr_i (mem_waddr),
    .mem_wdata_i (mem_wdata)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic chk_beat(input string tag, input logic [3:0] id, input logic [31:0] data,
                          input logic [1:0] resp, input logic last);
    check({tag, ".rvalid"}, 32'(rvalid), 32'd1);
    check({tag, ".rid"},    32'(rid),    32'(id));
    check({tag, ".rdata"},  rdata,       data);
    check({tag, ".rresp"},  32'(rresp),  32'(resp));
    check({tag, ".rlast"},  32'(rlast),  32'(last));
  endtask

  task automatic ar_send(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    check($sformatf("ar_ready_id%0d", id), 32'(arready), 32'd1);
    arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
    tick();
    arvalid = 1'b0;
  endtask

  task automatic mem_wr(input logic [7:0] idx, input logic [31:0] data);
    mem_we = 1'b1; mem_waddr = idx; mem_wdata = data;
    tick();
    mem_we = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] exp_incr [4];
    logic [31:0] exp_wrap [4];
    exp_incr = '{D0, D1, D2, D3};
    exp_wrap = '{D2, D3, D0, D1};

    rst = 1'b1; rready = 1'b0; mem_we = 1'b0; mem_waddr = '0; mem_wdata = '0;
    arid = 4'h5; araddr = '0; arlen = '0; arsize = 3'd2; arburst = 2'b01; arvalid = 1'b1;

    // reset with AR held valid
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("rst%0d_arready", i), 32'(arready), 32'd0);
      check($sformatf("rst%0d_rvalid", i),  32'(rvalid),  32'd0);
    end
    rst = 1'b0; arvalid = 1'b0;
    tick();
    check("post_rst_arready", 32'(arready), 32'd1);
    check("post_rst_rvalid",  32'(rvalid),  32'd0);
    check("post_rst_rid",     32'(rid),     32'd0);
    check("post_rst_rdata",   rdata,        32'd0);
    check("post_rst_rresp",   32'(rresp),   32'd0);
    check("post_rst_rlast",   32'(rlast),   32'd0);

    mem_wr(8'd0, D0);
    mem_wr(8'd1, D1);
    mem_wr(8'd2, D2);
    mem_wr(8'd3, D3);
    mem_wr(8'd255, DL);

    // INCR, 4 beats back to back
    rready = 1'b1;
    ar_send(4'h3, 32'h0, 8'd3, 3'd2, 2'b01);
    for (int b = 0; b < 4; b++) begin
      if (b > 0) tick();
      chk_beat($sformatf("incr%0d", b), 4'h3, exp_incr[b], 2'b00, b == 3);
`ifndef AXI_RD_MEM_AR_FIFO_EN
      check($sformatf("incr%0d_arready", b), 32'(arready), 32'd0);
`endif
    end
    tick();
    check("incr_done_rvalid", 32'(rvalid), 32'd0);
    check("incr_done_arready", 32'(arready), 32'd1);

    // WRAP with stalls
    rready = 1'b0;
    ar_send(4'h7, 32'h8, 8'd3, 3'd2, 2'b10);
    for (int b = 0; b < 4; b++) begin
      chk_beat($sformatf("wrap%0d", b), 4'h7, exp_wrap[b], 2'b00, b == 3);
      tick();
      chk_beat($sformatf("wrap%0d_stall", b), 4'h7, exp_wrap[b], 2'b00, b == 3);
      rready = 1'b1;
      tick();
      rready = 1'b0;
    end
    check("wrap_done_rvalid", 32'(rvalid), 32'd0);

    // out-of-range second beat
    rready = 1'b1;
    ar_send(4'hA, 32'h3FC, 8'd1, 3'd2, 2'b01);
    chk_beat("edge0", 4'hA, DL, 2'b00, 1'b0);
    tick();
    chk_beat("edge1", 4'hA, 32'h0, 2'b10, 1'b1);
    tick();

    // reserved burst type
    ar_send(4'hB, 32'h0, 8'd1, 3'd2, 2'b11);
    chk_beat("rsvd0", 4'hB, 32'h0, 2'b10, 1'b0);
    tick();
    chk_beat("rsvd1", 4'hB, 32'h0, 2'b10, 1'b1);
    tick();

    // oversize beat
    ar_send(4'hC, 32'h0, 8'd0, 3'd3, 2'b01);
    chk_beat("size0", 4'hC, 32'h0, 2'b10, 1'b1);
    tick();

    // WRAP with illegal length 2
    ar_send(4'hD, 32'h0, 8'd2, 3'd2, 2'b10);
    for (int b = 0; b < 3; b++) begin
      if (b > 0) tick();
      chk_beat($sformatf("badwrap%0d", b), 4'hD, 32'h0, 2'b10, b == 2);
    end
    tick();
    check("badwrap_done_rvalid", 32'(rvalid), 32'd0);

    // FIXED with memory update during stall and on a load edge
    rready = 1'b0;
    ar_send(4'h5, 32'h4, 8'd2, 3'd2, 2'b00);
    chk_beat("fix0", 4'h5, D1, 2'b00, 1'b0);
    mem_wr(8'd1, N1);
    chk_beat("fix0_held", 4'h5, D1, 2'b00, 1'b0);
    rready = 1'b1;
    tick();
    chk_beat("fix1", 4'h5, N1, 2'b00, 1'b0);
    mem_we = 1'b1; mem_waddr = 8'd1; mem_wdata = N2;
    tick();
    mem_we = 1'b0;
    chk_beat("fix2", 4'h5, N1, 2'b00, 1'b1);
    tick();
    check("fix_done_rvalid", 32'(rvalid), 32'd0);

`ifdef AXI_RD_MEM_AR_FIFO_EN
    // queue fill and back-to-back drain
    rready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("q_ready%0d", i), 32'(arready), 32'd1);
      arid = 4'(i + 1); araddr = 32'(i * 4); arlen = 8'd0; arsize = 3'd2; arburst = 2'b01;
      arvalid = 1'b1;
      tick();
    end
    check("q_full", 32'(arready), 32'd0);
    arid = 4'h5; araddr = 32'h0;
    tick();
    check("q_full_hold", 32'(arready), 32'd0);
    chk_beat("q_id1", 4'h1, D0, 2'b00, 1'b1);
    rready = 1'b1;
    tick();
    chk_beat("q_id2", 4'h2, N2, 2'b00, 1'b1);
    check("q_ready_after_pop", 32'(arready), 32'd1);
    tick();
    arvalid = 1'b0;
    chk_beat("q_id3", 4'h3, D2, 2'b00, 1'b1);
    tick();
    chk_beat("q_id4", 4'h4, D3, 2'b00, 1'b1);
    tick();
    chk_beat("q_id5", 4'h5, D0, 2'b00, 1'b1);
    tick();
    check("q_drained_rvalid", 32'(rvalid), 32'd0);
`endif

    // reset in the middle of a burst
    rready = 1'b0;
    ar_send(4'h9, 32'h0, 8'd3, 3'd2, 2'b01);
    arid = 4'hA; araddr = 32'h4; arlen = 8'd0; arvalid = 1'b1;
    tick();
    arid = 4'hB;
    tick();
    arvalid = 1'b0;
    chk_beat("mid_stall", 4'h9, D0, 2'b00, 1'b0);
    rst = 1'b1;
    tick();
    check("mid_rst_rvalid",  32'(rvalid),  32'd0);
    check("mid_rst_arready", 32'(arready), 32'd0);
    rst = 1'b0;
    tick();
    check("mid_rel_arready", 32'(arready), 32'd1);
    rready = 1'b1;
    ar_send(4'hC, 32'h8, 8'd0, 3'd2, 2'b01);
    chk_beat("post_mid", 4'hC, D2, 2'b00, 1'b1);
    tick();
    check("post_mid_empty", 32'(rvalid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
